game_seq_engine: RTL and testbench
==================================

GAME_SEQ_ENGINE -- requirements
Module: game_seq_engine

Interface
REQ-001 SHALL have parameter NOTE_W, default 3, bits per note; note value 0 means silence.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum sequence length in notes.
REQ-003 SHALL have parameter START_LEN, default 3, sequence length of the first round; legal range 1..MAX_LEN.
REQ-004 SHALL have parameter TICK_DIV, default 2500000, clk cycles per tick; minimum 1.
REQ-005 SHALL have parameters ON_TICKS, default 3, and OFF_TICKS, default 1, note-on and gap durations in ticks; minimum 1 each.
REQ-006 SHALL have parameter LIVES, default 3, misses allowed per game; minimum 1.
REQ-007 SHALL have parameter TIMEOUT_TICKS, default 0, key-wait timeout in ticks; 0 disables the timeout.
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-009 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port load, input, 1 bit, one-cycle pattern-load strobe.
REQ-011 SHALL have port pattern_in, input, MAX_LEN*NOTE_W bits; note i occupies bits [i*NOTE_W +: NOTE_W].
REQ-012 SHALL have ports start, input, 1 bit, game-start strobe; key_valid, input, 1 bit, one-cycle key strobe; and key_code, input, NOTE_W bits.
REQ-013 SHALL have port note_out, output, NOTE_W bits, registered piezo/LED drive.
REQ-014 SHALL have outputs playing (1b), cur_len ($clog2(MAX_LEN+1)b), lives_out ($clog2(LIVES+1)b), score (8b), hit (1b pulse), miss (1b pulse), game_win (1b), game_over (1b) and state_out (3b).

Function
REQ-015 SHALL use state_out encodings IDLE=0, PLAY_ON=1, PLAY_OFF=2, WAIT_KEY=3, WIN=4, GAME_OVER=5.
REQ-016 SHALL generate the tick prescaler as a one-cycle pulse every TICK_DIV cycles, cleared on every entry to PLAY_ON and WAIT_KEY.
REQ-017 SHALL accept load only in IDLE, WIN or GAME_OVER: it stores pattern_in and sets an internal loaded flag; load in other states is ignored.
REQ-018 SHALL accept start only in IDLE, WIN or GAME_OVER with loaded=1, or with load asserted in the same cycle, where the new pattern is used.
REQ-019 SHALL, on start acceptance, set cur_len=START_LEN, lives_out=LIVES, score=0, idx=0, game_win=0, game_over=0, and enter PLAY_ON.
REQ-020 SHALL ignore start in PLAY_ON, PLAY_OFF and WAIT_KEY.
REQ-021 SHALL drive note_out=pattern[idx] for exactly ON_TICKS*TICK_DIV cycles in PLAY_ON, starting the cycle after entry, then enter PLAY_OFF.
REQ-022 SHALL drive note_out=0 for OFF_TICKS*TICK_DIV cycles in PLAY_OFF, then: if idx==cur_len-1, set idx=0 and enter WAIT_KEY; else set idx+1 and enter PLAY_ON.
REQ-023 SHALL drive playing=1 exactly while in PLAY_ON or PLAY_OFF.
REQ-024 SHALL ignore key_valid outside WAIT_KEY, with no hit, no miss and no state change.
REQ-025 SHALL, in WAIT_KEY with key_valid and key_code==pattern[idx], pulse hit for one cycle and advance idx by one.
REQ-026 SHALL, on a correct key at idx==cur_len-1, increment score; if cur_len==MAX_LEN, enter WIN with game_win=1; otherwise set cur_len+1, idx=0 and enter PLAY_ON.
REQ-027 SHALL, in WAIT_KEY with key_valid and a wrong key_code, pulse miss for one cycle and decrement lives_out.
REQ-028 SHALL, on a miss when lives_out was 1, enter GAME_OVER with game_over=1 and lives_out=0; otherwise set idx=0 and replay at the same cur_len (enter PLAY_ON).
REQ-029 SHALL, with TIMEOUT_TICKS>0, treat TIMEOUT_TICKS ticks in WAIT_KEY without key_valid as a miss; the timeout counter restarts on each accepted key.
REQ-030 SHALL hold note_out=0 in IDLE, WAIT_KEY, WIN and GAME_OVER.
REQ-031 SHALL saturate score at 255.
REQ-032 SHALL keep the pattern and loaded flag unchanged across start, WIN and GAME_OVER.

Reset
REQ-033 SHALL, while reset_n=0, immediately force state IDLE, note_out=0, playing=0, cur_len=0, lives_out=0, score=0, hit=0, miss=0, game_win=0, game_over=0, loaded=0, idx=0, and clear the prescaler and timeout counters.
REQ-034 SHALL honour reset asserted mid-playback with no further note output; a start after reset is ignored until a new load.

Verification (bench parameters: NOTE_W=3, MAX_LEN=3, START_LEN=2, TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1, LIVES=2, pattern notes 5,3,6)
REQ-035 SHALL cover load then start: note_out=5 for 4 cycles, 0 for 2 cycles, 3 for 4 cycles, 0 for 2 cycles, then state_out=3 and playing=0.
REQ-036 SHALL cover keys 5,3 in WAIT_KEY: two hit pulses, score=1, cur_len=3, replay 5,3,6; then keys 5,3,6 give state_out=4, game_win=1 and score=2.
REQ-037 SHALL cover a wrong key 4 at idx 0: miss pulse, lives_out=1, replay of 5,3; a second wrong key gives game_over=1, lives_out=0, state_out=5.
REQ-038 SHALL cover key_valid and start pulsed during PLAY_ON: no hit or miss, and the playback timing is unchanged.
REQ-039 SHALL cover TIMEOUT_TICKS=4 with no key: miss after 8 cycles in WAIT_KEY and lives_out=1.
REQ-040 SHALL cover start without a prior load: ignored, state_out=0; reset_n low during PLAY_ON forces note_out=0 and state_out=0 in the same cycle.

Source files
------------

// File: rtl/game_seq_engine.sv
// game_seq_engine: memory-game sequencer ("play the tune back").
// A pattern of notes is loaded, then played out note by note for rounds of
// growing length. After each playback the player must repeat the sequence on
// the keypad; a full correct repeat grows the sequence, a wrong key (or a
// key-wait timeout) costs a life and replays the round.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   load, pattern_in       pattern-load strobe and packed notes (note i at [i*NOTE_W +: NOTE_W])
//   start                  game-start strobe
//   key_valid, key_code    one-cycle key strobe and key value
//   note_out               registered note drive (0 = silence)
//   playing                high while a sequence is being played out
//   cur_len, lives_out     current round length, lives remaining
//   score                  rounds completed, saturating at 255
//   hit, miss              one-cycle result pulses for each judged key
//   game_win, game_over    sticky end-of-game flags
//   state_out              FSM state (IDLE=0 .. GAME_OVER=5)
module game_seq_engine #(
  parameter int NOTE_W        = 3,
  parameter int MAX_LEN       = 8,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 2500000,
  parameter int ON_TICKS      = 3,
  parameter int OFF_TICKS     = 1,
  parameter int LIVES         = 3,
  parameter int TIMEOUT_TICKS = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              load,
  input  logic [MAX_LEN*NOTE_W-1:0]         pattern_in,
  input  logic                              start,
  input  logic                              key_valid,
  input  logic [NOTE_W-1:0]                 key_code,
  output logic [NOTE_W-1:0]                 note_out,
  output logic                              playing,
  output logic [$clog2(MAX_LEN+1)-1:0]      cur_len,
  output logic [$clog2(LIVES+1)-1:0]        lives_out,
  output logic [7:0]                        score,
  output logic                              hit,
  output logic                              miss,
  output logic                              game_win,
  output logic                              game_over,
  output logic [2:0]                        state_out
);

  localparam int LW    = $clog2(MAX_LEN+1);
  localparam int VW    = $clog2(LIVES+1);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAXT  = (TIMEOUT_TICKS > MAXT0) ? TIMEOUT_TICKS : MAXT0;
  localparam int DW    = $clog2(MAXT+1);
  localparam int TO_M1 = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS-1 : 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_OFF  = 3'd2,
    S_WAIT = 3'd3,
    S_WIN  = 3'd4,
    S_OVER = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_LEN*NOTE_W-1:0] pat_q, pat_d;
  logic                      loaded_q, loaded_d;
  logic [LW-1:0]             idx_q, idx_d;
  logic [LW-1:0]             len_q, len_d;
  logic [VW-1:0]             lives_q, lives_d;
  logic [7:0]                score_q, score_d;
  logic                      hit_q, hit_d, miss_q, miss_d;
  logic                      win_q, win_d, over_q, over_d;
  logic [NOTE_W-1:0]         note_q, note_d;
  logic [PW-1:0]             pre_q, pre_d;   // tick prescaler
  logic [DW-1:0]             dur_q, dur_d;   // ticks spent in the current state

  logic              tick, last, do_miss, restart;
  logic [NOTE_W-1:0] cur_note;

  assign tick     = (pre_q == PW'(TICK_DIV-1));
  assign cur_note = pat_q[int'(idx_q)*NOTE_W +: NOTE_W];
  assign last     = (idx_q == len_q - LW'(1));

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    loaded_d = loaded_q;
    idx_d    = idx_q;
    len_d    = len_q;
    lives_d  = lives_q;
    score_d  = score_q;
    win_d    = win_q;
    over_d   = over_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    do_miss  = 1'b0;
    restart  = 1'b0;
    pre_d    = tick ? '0 : pre_q + PW'(1);
    dur_d    = dur_q;
    // Saturate so a long idle wait (timeout disabled) cannot wrap.
    if (tick && dur_q != '1) dur_d = dur_q + DW'(1);

    case (state_q)
      S_IDLE, S_WIN, S_OVER: begin
        if (load) begin
          pat_d    = pattern_in;
          loaded_d = 1'b1;
        end
        if (start && (loaded_q || load)) begin
          len_d   = LW'(START_LEN);
          lives_d = VW'(LIVES);
          score_d = '0;
          idx_d   = '0;
          win_d   = 1'b0;
          over_d  = 1'b0;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (tick && dur_q == DW'(ON_TICKS-1)) state_d = S_OFF;
      end
      S_OFF: begin
        if (tick && dur_q == DW'(OFF_TICKS-1)) begin
          if (last) begin
            idx_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = S_ON;
          end
        end
      end
      S_WAIT: begin
        if (key_valid) begin
          if (key_code == cur_note) begin
            hit_d   = 1'b1;
            restart = 1'b1;
            if (last) begin
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
              if (len_q == LW'(MAX_LEN)) begin
                win_d   = 1'b1;
                state_d = S_WIN;
              end else begin
                len_d   = len_q + LW'(1);
                idx_d   = '0;
                state_d = S_ON;
              end
            end else begin
              idx_d = idx_q + LW'(1);
            end
          end else begin
            do_miss = 1'b1;
          end
        end else if (TIMEOUT_TICKS > 0 && tick && dur_q == DW'(TO_M1)) begin
          do_miss = 1'b1;
        end
        if (do_miss) begin
          miss_d = 1'b1;
          if (lives_q == VW'(1)) begin
            lives_d = '0;
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - VW'(1);
            idx_d   = '0;
            state_d = S_ON;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state change (and every accepted key) starts timing afresh.
    if (state_d != state_q || restart) begin
      pre_d = '0;
      dur_d = '0;
    end

    // Note register follows the next state so the note sounds for the whole
    // PLAY_ON interval; the next pattern covers a same-cycle load+start.
    note_d = (state_d == S_ON) ? pat_d[int'(idx_d)*NOTE_W +: NOTE_W] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      loaded_q <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
      lives_q  <= '0;
      score_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      win_q    <= 1'b0;
      over_q   <= 1'b0;
      note_q   <= '0;
      pre_q    <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      win_q    <= win_d;
      over_q   <= over_d;
      note_q   <= note_d;
      pre_q    <= pre_d;
      dur_q    <= dur_d;
    end
  end

  assign note_out  = note_q;
  assign playing   = (state_q == S_ON) || (state_q == S_OFF);
  assign cur_len   = len_q;
  assign lives_out = lives_q;
  assign score     = score_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign game_win  = win_q;
  assign game_over = over_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_game_seq_engine.sv
// Scoreboard bench for game_seq_engine. Instance A (no timeout) runs the main
// game flow; instance B (TIMEOUT_TICKS=4) exercises the key-wait timeout.
// Expected hit/miss events and note runs are queued by the stimulus and
// consumed by independent monitors.
module tb_game_seq_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, load, start, key_valid;
  logic [8:0] pattern_in;
  logic [2:0] key_code;
  logic       b_load, b_start, b_key_valid;
  logic [2:0] b_key_code;

  logic [2:0] a_note, a_st, b_note, b_st;
  logic       a_playing, a_hit, a_miss, a_win, a_over;
  logic       b_playing, b_hit, b_miss, b_win, b_over;
  logic [1:0] a_len, a_lives, b_len, b_lives;
  logic [7:0] a_score, b_score;

  game_seq_engine #(.NOTE_W(3), .MAX_LEN(3), .START_LEN(2), .TICK_DIV(2),
    .ON_TICKS(2), .OFF_TICKS(1), .LIVES(2), .TIMEOUT_TICKS(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load), .pattern_in(pattern_in),
    .start(start), .key_valid(key_valid), .key_code(key_code),
    .note_out(a_note), .playing(a_playing), .cur_len(a_len), .lives_out(a_lives),
    .score(a_score), .hit(a_hit), .miss(a_miss), .game_win(a_win),
    .game_over(a_over), .state_out(a_st));

  game_seq_engine #(.NOTE_W(3), .MAX_LEN(3), .START_LEN(2), .TICK_DIV(2),
    .ON_TICKS(2), .OFF_TICKS(1), .LIVES(2), .TIMEOUT_TICKS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(b_load), .pattern_in(pattern_in),
    .start(b_start), .key_valid(b_key_valid), .key_code(b_key_code),
    .note_out(b_note), .playing(b_playing), .cur_len(b_len), .lives_out(b_lives),
    .score(b_score), .hit(b_hit), .miss(b_miss), .game_win(b_win),
    .game_over(b_over), .state_out(b_st));

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [2:0] st;
    logic [7:0] score;
    logic [1:0] lives;
    logic [1:0] len;
  } ev_t;

  typedef struct packed {
    logic [2:0] val;
    logic [7:0] len;
  } run_t;

  ev_t  qa[$], qb[$];
  run_t qr[$];
  int   checks = 0, failures = 0;
  logic [2:0] pat [3] = '{3'd5, 3'd3, 3'd6};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic h, input logic m, input logic [2:0] st,
                                input logic [7:0] sc, input logic [1:0] lv, input logic [1:0] ln);
    mk_ev = {h, m, st, sc, lv, ln};
  endfunction

  // Each round plays n notes: ON 2 ticks * 2 cycles, then OFF 1 tick * 2 cycles.
  task automatic push_play(input int n);
    for (int k = 0; k < n; k++) begin
      qr.push_back({pat[k], 8'd4});
      qr.push_back({3'd0, 8'd2});
    end
  endtask

  task automatic pop_event(input string nm, input ev_t got, input bit use_b);
    ev_t e;
    if ((use_b ? qb.size() : qa.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event %0h", nm, got);
    end else begin
      e = use_b ? qb.pop_front() : qa.pop_front();
      chk(nm, 32'(got), 32'(e));
    end
  endtask

  // Event monitors: compare state snapshot on every hit/miss pulse.
  initial forever begin
    @(negedge clk);
    if (reset_n && (a_hit || a_miss))
      pop_event("event_a", {a_hit, a_miss, a_st, a_score, a_lives, a_len}, 1'b0);
    if (reset_n && (b_hit || b_miss))
      pop_event("event_b", {b_hit, b_miss, b_st, b_score, b_lives, b_len}, 1'b1);
  end

  // Note-run monitor on A: compresses note_out into (value, length) runs while
  // playing; a run interrupted by reset is discarded.
  initial begin
    logic [2:0] rv;
    int rl;
    bit inr;
    run_t e;
    rv = '0; rl = 0; inr = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) inr = 0;
      else if (a_playing && inr && a_note == rv) rl++;
      else if (inr) begin
        if (qr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL note_run: unexpected run note %0d len %0d", rv, rl);
        end else begin
          e = qr.pop_front();
          chk("note_run", {21'd0, rv, rl[7:0]}, {21'd0, e});
        end
        inr = 0;
        if (a_playing) begin rv = a_note; rl = 1; inr = 1; end
      end else if (a_playing) begin
        rv = a_note; rl = 1; inr = 1;
      end
    end
  end

  task automatic wait_st(input bit use_b, input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while ((use_b ? b_st : a_st) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(use_b ? b_st : a_st), 32'(s));
  endtask

  task automatic pa_key(input logic [2:0] k);
    @(posedge clk); #1 key_valid = 1'b1; key_code = k;
    @(posedge clk); #1 key_valid = 1'b0;
  endtask

  task automatic pa_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; load = 0; start = 0; key_valid = 0; key_code = '0;
    b_load = 0; b_start = 0; b_key_valid = 0; b_key_code = '0;
    pattern_in = {3'd6, 3'd3, 3'd5};
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(a_st), 0);
    chk("rst_note", 32'(a_note), 0);
    chk("rst_playing", 32'(a_playing), 0);
    chk("rst_len_lives_score", {a_len, a_lives, a_score}, 0);
    chk("rst_flags", {a_hit, a_miss, a_win, a_over}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Timeout on B, with load and start in the same cycle.
    qb.push_back(mk_ev(0, 1, 3'd1, 8'd0, 2'd1, 2'd2));
    qb.push_back(mk_ev(0, 1, 3'd5, 8'd0, 2'd0, 2'd2));
    @(posedge clk); #1 b_load = 1'b1; b_start = 1'b1;
    @(posedge clk); #1 b_load = 1'b0; b_start = 1'b0;
    wait_st(1, 3'd3, 60, "b_wait_key");
    n = 0;
    while (b_st == 3'd3 && n < 50) begin @(negedge clk); n++; end
    chk("b_timeout_cycles", 32'(n), 8);
    chk("b_miss_pulse", 32'(b_miss), 1);
    chk("b_lives_after_timeout", 32'(b_lives), 1);
    wait_st(1, 3'd5, 100, "b_game_over_state");
    chk("b_game_over_flag", 32'(b_over), 1);

    // Start without a prior load is ignored.
    pa_start();
    @(negedge clk);
    chk("start_no_load", 32'(a_st), 0);

    // Load, start; key and start pulsed during PLAY_ON must change nothing.
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    push_play(2);
    pa_start();
    key_valid = 1'b1; key_code = 3'd5; start = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0; start = 1'b0;
    wait_st(0, 3'd3, 60, "a_wait1");
    chk("a_wait1_playing", 32'(a_playing), 0);
    chk("a_wait1_len_lives_score", {a_len, a_lives, a_score}, {2'd2, 2'd2, 8'd0});

    // Correct repeat of round 1 grows the sequence.
    qa.push_back(mk_ev(1, 0, 3'd3, 8'd0, 2'd2, 2'd2));
    pa_key(3'd5);
    qa.push_back(mk_ev(1, 0, 3'd1, 8'd1, 2'd2, 2'd3));
    push_play(3);
    pa_key(3'd3);
    wait_st(0, 3'd3, 100, "a_wait2");
    chk("a_wait2_len_score", {a_len, a_score}, {2'd3, 8'd1});

    // Full-length repeat wins.
    qa.push_back(mk_ev(1, 0, 3'd3, 8'd1, 2'd2, 2'd3));
    pa_key(3'd5);
    qa.push_back(mk_ev(1, 0, 3'd3, 8'd1, 2'd2, 2'd3));
    pa_key(3'd3);
    qa.push_back(mk_ev(1, 0, 3'd4, 8'd2, 2'd2, 2'd3));
    pa_key(3'd6);
    @(negedge clk);
    chk("a_win_state", 32'(a_st), 4);
    chk("a_win_flag_score", {a_win, a_score}, {1'b1, 8'd2});

    // Restart from WIN keeps the pattern; then two misses end the game.
    push_play(2);
    pa_start();
    wait_st(0, 3'd3, 60, "a_wait3");
    chk("a_restart_values", {a_win, a_len, a_lives, a_score}, {1'b0, 2'd2, 2'd2, 8'd0});
    qa.push_back(mk_ev(0, 1, 3'd1, 8'd0, 2'd1, 2'd2));
    push_play(2);
    pa_key(3'd4);
    wait_st(0, 3'd3, 60, "a_wait4");
    chk("a_lives_after_miss", 32'(a_lives), 1);
    qa.push_back(mk_ev(0, 1, 3'd5, 8'd0, 2'd0, 2'd2));
    pa_key(3'd3);
    @(negedge clk);
    chk("a_over_state", 32'(a_st), 5);
    chk("a_over_flag_lives", {a_over, a_lives}, {1'b1, 2'd0});

    // Reset during playback silences the note immediately.
    pa_start();
    #2 chk("a_note_before_reset", 32'(a_note), 5);
    reset_n = 1'b0;
    #1 chk("a_note_in_reset", 32'(a_note), 0);
    chk("a_state_in_reset", 32'(a_st), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    pa_start();
    repeat (3) @(negedge clk);
    chk("a_start_after_reset", {a_st, a_note, a_playing}, 0);

    repeat (3) @(negedge clk);
    chk("queues_drained", qa.size() + qb.size() + qr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
